// File: rtl/bridge_pkg.sv
// Shared definitions for the ASCII command bridges: parser state encoding,
// command/terminator byte codes and the core-chain bus widths.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    TERM = 2'd3
  } bridge_rx_state_t;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;

  // True for the two bytes that open a message.
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == ASCII_R) || (b == ASCII_W);
  endfunction

  // True for either line terminator.
  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/bridge_rx_if.sv
// Byte stream in from the UART receiver and request bus out to the core chain.
// The bridge uses the master view; the environment (UART + chain) the slave view.
interface bridge_rx_if;
  import bridge_pkg::*;

  logic [7:0]            data_i;
  logic                  valid_i;
  logic [BUS_ADDR_W-1:0] addr_o;
  logic [BUS_DATA_W-1:0] data_o;
  logic                  rw_o;
  logic                  valid_o;
  logic                  error_o;

  modport master (
    input  data_i, valid_i,
    output addr_o, data_o, rw_o, valid_o, error_o
  );

  modport slave (
    output data_i, valid_i,
    input  addr_o, data_o, rw_o, valid_o, error_o
  );
endinterface

// File: rtl/hex_decode.sv
// Combinational ASCII hex digit decoder: byte -> nibble value plus a valid flag.
// Lowercase a-f are accepted only when BRIDGE_RX_LOWERCASE_EN is defined.
module hex_decode (
  input  logic [7:0] byte_i,
  output logic [3:0] nib_o,
  output logic       is_hex_o
);

  // Classify the byte; letters map to 10..15 via their low nibble plus nine.
  always_comb begin
    nib_o    = 4'd0;
    is_hex_o = 1'b0;
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      nib_o    = byte_i[3:0];
      is_hex_o = 1'b1;
    end else if (byte_i >= 8'h41 && byte_i <= 8'h46) begin
      nib_o    = byte_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
`ifdef BRIDGE_RX_LOWERCASE_EN
    else if (byte_i >= 8'h61 && byte_i <= 8'h66) begin
      nib_o    = byte_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/bridge_rx.sv
// ASCII command parser feeding the core-chain bus. Accepts "Raaaa<term>" and
// "Wddddvvvv<term>" messages and issues one registered request per message;
// malformed messages are dropped with a one-cycle error pulse.
// Optional feature macro: BRIDGE_RX_LOWERCASE_EN (lowercase hex digits).
module bridge_rx
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  bridge_rx_if.master bus
);

  bridge_rx_state_t      state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [BUS_ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [BUS_DATA_W-1:0] data_sh_q, data_sh_d;
  logic [BUS_ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_DATA_W-1:0] data_q, data_d;
  logic                  rw_q, rw_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  logic [3:0] nib;
  logic       is_hex;

  hex_decode u_hex (
    .byte_i   (bus.data_i),
    .nib_o    (nib),
    .is_hex_o (is_hex)
  );

  // Parser next-state: shift digits, detect terminators, raise request/error.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = rw_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    if (bus.valid_i) begin
      if (is_cmd(bus.data_i)) begin
        // A command byte always (re)starts a message; mid-message it also
        // flags the abandoned one.
        wr_d    = (bus.data_i == ASCII_W);
        cnt_d   = 2'd0;
        state_d = ADDR;
        error_d = (state_q != IDLE);
      end else begin
        case (state_q)
          IDLE: ;  // stray bytes between messages (e.g. LF of CRLF) are ignored
          ADDR: begin
            if (is_hex) begin
              addr_sh_d = {addr_sh_q[BUS_ADDR_W-5:0], nib};
              cnt_d     = cnt_q + 2'd1;
              if (cnt_q == 2'd3) state_d = wr_q ? DATA : TERM;
            end else begin
              error_d = 1'b1;
              state_d = IDLE;
            end
          end
          DATA: begin
            if (is_hex) begin
              data_sh_d = {data_sh_q[BUS_DATA_W-5:0], nib};
              cnt_d     = cnt_q + 2'd1;
              if (cnt_q == 2'd3) state_d = TERM;
            end else begin
              error_d = 1'b1;
              state_d = IDLE;
            end
          end
          TERM: begin
            if (is_term(bus.data_i)) begin
              valid_d = 1'b1;
              addr_d  = addr_sh_q;
              data_d  = wr_q ? data_sh_q : '0;
              rw_d    = wr_q;
            end else begin
              error_d = 1'b1;
            end
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Control and bus output registers; all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  // Digit shift registers; contents only matter once a full field is seen.
  always_ff @(posedge clk) begin
    addr_sh_q <= addr_sh_d;
    data_sh_q <= data_sh_d;
  end

  assign bus.addr_o  = addr_q;
  assign bus.data_o  = data_q;
  assign bus.rw_o    = rw_q;
  assign bus.valid_o = valid_q;
  assign bus.error_o = error_q;

endmodule

// File: tb/tb_bridge_rx.sv
// Directed bench for bridge_rx: sends ASCII messages byte by byte and checks
// request/error strobes and bus values against hand-computed expectations.
module tb_bridge_rx;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  int vcnt = 0, ecnt = 0, both = 0, seen12 = 0;
  int v0, e0;

  bridge_rx_if ifc ();

  bridge_rx u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Strobe monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (ifc.valid_o) vcnt++;
    if (ifc.error_o) ecnt++;
    if (ifc.valid_o && ifc.error_o) both++;
    if (ifc.addr_o[15:8] == 8'h12) seen12++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte, valid for exactly one edge; returns 1 time unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    ifc.data_i  = b;
    ifc.valid_i = 1'b1;
    @(posedge clk);
    #1;
    ifc.valid_i = 1'b0;
    ifc.data_i  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    v0 = vcnt;
    e0 = ecnt;
  endtask

  initial begin
    rst_n       = 1'b0;
    ifc.data_i  = 8'h00;
    ifc.valid_i = 1'b0;
    idle(3);
    check("rst_valid", {31'd0, ifc.valid_o}, 32'd0);
    check("rst_error", {31'd0, ifc.error_o}, 32'd0);
    check("rst_addr",  {16'd0, ifc.addr_o},  32'd0);
    check("rst_data",  {16'd0, ifc.data_o},  32'd0);
    check("rst_rw",    {31'd0, ifc.rw_o},    32'd0);
    rst_n = 1'b1;
    idle(1);

    // Plain read
    mark();
    send_str("R0007");
    check("rd_no_early_valid", {31'd0, ifc.valid_o}, 32'd0);
    send_byte(8'h0D);
    check("rd_valid", {31'd0, ifc.valid_o}, 32'd1);
    check("rd_addr",  {16'd0, ifc.addr_o},  32'h0007);
    check("rd_rw",    {31'd0, ifc.rw_o},    32'd0);
    check("rd_data",  {16'd0, ifc.data_o},  32'h0000);
    idle(1);
    check("rd_valid_width", {31'd0, ifc.valid_o}, 32'd0);
    check("rd_addr_held",   {16'd0, ifc.addr_o},  32'h0007);
    idle(1);
    check("rd_vcount", vcnt - v0, 32'd1);
    check("rd_ecount", ecnt - e0, 32'd0);

    // Write with LF, then a stray CRLF back-to-back
    mark();
    send_str("W0006BEEF");
    send_byte(8'h0A);
    check("wr_valid", {31'd0, ifc.valid_o}, 32'd1);
    check("wr_addr",  {16'd0, ifc.addr_o},  32'h0006);
    check("wr_data",  {16'd0, ifc.data_o},  32'hBEEF);
    check("wr_rw",    {31'd0, ifc.rw_o},    32'd1);
    send_byte(8'h0D);
    send_byte(8'h0A);
    idle(2);
    check("wr_vcount", vcnt - v0, 32'd1);
    check("wr_ecount", ecnt - e0, 32'd0);

    // Bad digit G (just past F), then recovery
    mark();
    send_str("R00G");
    check("bad_g_error", {31'd0, ifc.error_o}, 32'd1);
    send_str("1");
    check("bad_g_error_width", {31'd0, ifc.error_o}, 32'd0);
    send_byte(8'h0D);
    idle(2);
    check("bad_g_vcount", vcnt - v0, 32'd0);
    check("bad_g_ecount", ecnt - e0, 32'd1);
    send_str("R0001");
    send_byte(8'h0D);
    check("rec_valid", {31'd0, ifc.valid_o}, 32'd1);
    check("rec_addr",  {16'd0, ifc.addr_o},  32'h0001);

    // Command byte mid-message restarts
    idle(1);
    mark();
    send_str("W12R");
    check("restart_error", {31'd0, ifc.error_o}, 32'd1);
    send_str("0002");
    send_byte(8'h0D);
    check("restart_valid", {31'd0, ifc.valid_o}, 32'd1);
    check("restart_addr",  {16'd0, ifc.addr_o},  32'h0002);
    check("restart_rw",    {31'd0, ifc.rw_o},    32'd0);
    check("restart_data",  {16'd0, ifc.data_o},  32'h0000);
    idle(2);
    check("restart_vcount", vcnt - v0, 32'd1);
    check("restart_ecount", ecnt - e0, 32'd1);
    check("never_0x12xx", seen12, 32'd0);

    // Hex boundaries 9/A/F/0 and a missing terminator
    mark();
    send_str("W9A0F0010");
    send_byte(8'h0D);
    check("bnd_addr", {16'd0, ifc.addr_o}, 32'h9A0F);
    check("bnd_data", {16'd0, ifc.data_o}, 32'h0010);
    check("bnd_rw",   {31'd0, ifc.rw_o},   32'd1);
    send_str("R0:");
    check("colon_error", {31'd0, ifc.error_o}, 32'd1);
    send_str("R@");
    check("at_error", {31'd0, ifc.error_o}, 32'd1);
    send_str("R12345");
    check("noterm_error", {31'd0, ifc.error_o}, 32'd1);
    idle(2);
    check("bnd_vcount", vcnt - v0, 32'd1);
    check("bnd_ecount", ecnt - e0, 32'd3);
    check("bnd_addr_held", {16'd0, ifc.addr_o}, 32'h9A0F);

    // Reset mid-message
    mark();
    send_str("W00");
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    send_str("00");
    send_byte(8'h0D);
    idle(2);
    check("mid_rst_addr",   {16'd0, ifc.addr_o}, 32'd0);
    check("mid_rst_data",   {16'd0, ifc.data_o}, 32'd0);
    check("mid_rst_rw",     {31'd0, ifc.rw_o},   32'd0);
    check("mid_rst_vcount", vcnt - v0, 32'd0);
    check("mid_rst_ecount", ecnt - e0, 32'd0);
    send_str("R000A");
    send_byte(8'h0D);
    check("post_rst_valid", {31'd0, ifc.valid_o}, 32'd1);
    check("post_rst_addr",  {16'd0, ifc.addr_o},  32'h000A);

    // Lowercase digits
    idle(1);
    mark();
    send_str("R00ab");
    send_byte(8'h0D);
`ifdef BRIDGE_RX_LOWERCASE_EN
    check("lc_valid", {31'd0, ifc.valid_o}, 32'd1);
    check("lc_addr",  {16'd0, ifc.addr_o},  32'h00AB);
    idle(2);
    check("lc_ecount", ecnt - e0, 32'd0);
`else
    idle(2);
    check("lc_vcount", vcnt - v0, 32'd0);
    check("lc_ecount", ecnt - e0, 32'd1);
    check("lc_addr_held", {16'd0, ifc.addr_o}, 32'h000A);
`endif

    check("never_both_strobes", both, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
